// File: rtl/pipeline_ctrl.sv
// Pipeline control sequencer: per-stage enables/flushes, data-memory wait and halt drain.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        exmem_dREN,
    input  logic        exmem_dWEN,
    input  logic        exmem_halt,
    input  logic        lw_nop,
    input  logic        jmp_flush,
    input  logic        brch_flush,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        imemREN,
    output logic        halted,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [1:0] RUN    = 2'b00;
    localparam logic [1:0] DWAIT  = 2'b01;
    localparam logic [1:0] DRAIN  = 2'b10;
    localparam logic [1:0] HALTED = 2'b11;

    logic [1:0] state_q, state_d;
    logic       halted_q;
    logic       dreq, adv, go, halt_take, flush_req;

    assign dreq      = exmem_dREN | exmem_dWEN;
    assign adv       = ihit & (~dreq | dhit);
    // A DWAIT exit advances the pipe even without ihit: the port was lent to data.
    assign go        = ((state_q == RUN) & adv) | ((state_q == DWAIT) & dhit);
    assign halt_take = (state_q == RUN) & adv & exmem_halt;
    assign flush_req = jmp_flush | brch_flush;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        imemREN     = 1'b0;
        state_d     = state_q;

        case (state_q)
            RUN: begin
                imemREN = 1'b1;
                if (!adv && dreq && !dhit) state_d = DWAIT;
            end
            DWAIT:   if (dhit) state_d = RUN;
            DRAIN: begin
                memwb_en = 1'b1;
                state_d  = HALTED;
            end
            default: state_d = HALTED;
        endcase

        if (go) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            // Halt in MEM is the oldest event; a younger flush or load-use is moot.
            if (halt_take) begin
                pc_en       = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                state_d     = DRAIN;
            end else if (flush_req) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lw_nop) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (RST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            imemREN     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALTED);
        end
    end

    assign halted = halted_q;

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;
    logic        stall_inc, flush_inc;

    assign flush_inc = go & ~halt_take & flush_req;
    assign stall_inc = (state_q == DWAIT) | ((state_q == RUN) & ~adv)
                     | (go & ~halt_take & ~flush_req & lw_nop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            if (stall_inc) stall_cnt_q <= stall_cnt_q + 32'h1;
            if (flush_inc) flush_cnt_q <= flush_cnt_q + 32'h1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'h0;
    assign flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, corner sequences,
// then randomized stimulus against a per-stage-action reference model.
module tb_pipeline_ctrl;

    logic        CLK, RST, ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt;
    logic        lw_nop, jmp_flush, brch_flush;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, imemREN, halted;
    logic [31:0] stall_cnt, flush_cnt;

    pipeline_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN), .exmem_halt(exmem_halt),
        .lw_nop(lw_nop), .jmp_flush(jmp_flush), .brch_flush(brch_flush),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .imemREN(imemREN),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        bit rst, ihit, dhit, dren, dwen, halt, lw, jmp, brch;
    } stim_t;

    // Expected output vector: {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes, imemREN}
    typedef struct {
        stim_t       s;
        logic [9:0]  o;
        bit          h;
        int unsigned sc;
        int unsigned fc;
    } vec_t;

    typedef enum {M_RUN, M_DWAIT, M_DRAIN, M_HALTED} mode_t;
    typedef enum {A_HOLD, A_ADV, A_BUB} act_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    mode_t       m_mode = M_RUN;
    bit          m_halted = 1'b0;
    logic [31:0] m_stall = 32'h0;
    logic [31:0] m_flush = 32'h0;

    function automatic stim_t mk(input bit r, ih, dh, dr, dw, ha, lw, jm, br);
        stim_t s;
        s = '{rst: r, ihit: ih, dhit: dh, dren: dr, dwen: dw, halt: ha, lw: lw, jmp: jm, brch: br};
        return s;
    endfunction

    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PIPE_PERF_EN
        return v;
`else
        return v & 32'h0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        RST        = s.rst;
        ihit       = s.ihit;
        dhit       = s.dhit;
        exmem_dREN = s.dren;
        exmem_dWEN = s.dwen;
        exmem_halt = s.halt;
        lw_nop     = s.lw;
        jmp_flush  = s.jmp;
        brch_flush = s.brch;
    endtask

    function automatic logic [9:0] dut_vec();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush, imemREN};
    endfunction

    // Reference model: decide what each latch does this cycle, then translate to strobes.
    task automatic predict(input stim_t s, output logic [9:0] o, output mode_t nxt,
                           output bit st, output bit fl);
        act_t a [5];
        bit   advance, dreq;
        nxt = m_mode; st = 1'b0; fl = 1'b0; advance = 1'b0;
        for (int i = 0; i < 5; i++) a[i] = A_HOLD;
        dreq = s.dren || s.dwen;
        case (m_mode)
            M_RUN: begin
                if (s.ihit && (!dreq || s.dhit)) advance = 1'b1;
                else begin
                    st = 1'b1;
                    if (dreq && !s.dhit) nxt = M_DWAIT;
                end
            end
            M_DWAIT: begin
                st = 1'b1;
                if (s.dhit) begin advance = 1'b1; nxt = M_RUN; end
            end
            M_DRAIN: begin a[4] = A_ADV; nxt = M_HALTED; end
            default: ;
        endcase
        if (advance) begin
            for (int i = 0; i < 5; i++) a[i] = A_ADV;
            if (m_mode == M_RUN && s.halt) begin
                a[0] = A_HOLD; a[1] = A_BUB; a[2] = A_BUB; a[3] = A_BUB;
                nxt = M_DRAIN;
            end else if (s.jmp || s.brch) begin
                a[1] = A_BUB; a[2] = A_BUB; fl = 1'b1;
            end else if (s.lw) begin
                a[0] = A_HOLD; a[1] = A_HOLD; a[2] = A_BUB; st = 1'b1;
            end
        end
        o = '0;
        for (int i = 0; i < 5; i++) o[9-i] = (a[i] != A_HOLD);
        for (int i = 1; i < 5; i++) o[5-i] = (a[i] == A_BUB);
        o[0] = (m_mode == M_RUN);
        if (s.rst) begin
            o = 10'b00000_1111_0;
            nxt = M_RUN; st = 1'b0; fl = 1'b0;
        end
    endtask

    task automatic step(input stim_t s);
        logic [9:0] o;
        mode_t      nxt;
        bit         st, fl;
        @(negedge CLK);
        drive(s);
        #1;
        cyc++;
        predict(s, o, nxt, st, fl);
        check("outputs", {22'h0, dut_vec()}, {22'h0, o});
        check("halted", {31'h0, halted}, {31'h0, m_halted});
        check("stall_cnt", stall_cnt, perf(m_stall));
        check("flush_cnt", flush_cnt, perf(m_flush));
        if (s.rst) begin
            m_mode = M_RUN; m_halted = 1'b0; m_stall = 32'h0; m_flush = 32'h0;
        end else begin
            m_mode   = nxt;
            m_halted = (nxt == M_HALTED);
            m_stall  = m_stall + {31'h0, st};
            m_flush  = m_flush + {31'h0, fl};
        end
    endtask

    vec_t tab [18];

    initial begin
        //             rst ih dh dr dw ha lw jm br        outputs          h  stall flush
        tab[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 10'b00000_1111_0, 1'b0, 0, 0};
        tab[1]  = '{mk(1, 1, 1, 1, 0, 1, 1, 1, 0), 10'b00000_1111_0, 1'b0, 0, 0};
        tab[2]  = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0), 10'b11111_0000_1, 1'b0, 0, 0};
        tab[3]  = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 0), 10'b00111_0100_1, 1'b0, 0, 0};
        tab[4]  = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0), 10'b11111_0000_1, 1'b0, 1, 0};
        tab[5]  = '{mk(0, 1, 0, 0, 0, 0, 1, 0, 1), 10'b11111_1100_1, 1'b0, 1, 0};
        tab[6]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 10'b00000_0000_1, 1'b0, 1, 1};
        tab[7]  = '{mk(0, 1, 0, 1, 0, 0, 0, 0, 0), 10'b00000_0000_1, 1'b0, 2, 1};
        tab[8]  = '{mk(0, 1, 0, 1, 0, 0, 0, 0, 0), 10'b00000_0000_0, 1'b0, 3, 1};
        tab[9]  = '{mk(0, 1, 0, 1, 0, 0, 0, 0, 0), 10'b00000_0000_0, 1'b0, 4, 1};
        tab[10] = '{mk(0, 0, 1, 1, 0, 0, 0, 0, 0), 10'b11111_0000_0, 1'b0, 5, 1};
        tab[11] = '{mk(0, 1, 0, 0, 0, 0, 0, 1, 0), 10'b11111_1100_1, 1'b0, 6, 1};
        tab[12] = '{mk(0, 1, 0, 0, 0, 1, 0, 0, 0), 10'b01111_1110_1, 1'b0, 6, 2};
        tab[13] = '{mk(0, 1, 1, 0, 1, 0, 1, 1, 0), 10'b00001_0000_0, 1'b0, 6, 2};
        tab[14] = '{mk(0, 1, 0, 0, 0, 0, 1, 1, 0), 10'b00000_0000_0, 1'b1, 6, 2};
        tab[15] = '{mk(0, 1, 1, 1, 1, 1, 0, 0, 1), 10'b00000_0000_0, 1'b1, 6, 2};
        tab[16] = '{mk(1, 1, 0, 0, 0, 0, 0, 0, 0), 10'b00000_1111_0, 1'b1, 6, 2};
        tab[17] = '{mk(0, 1, 0, 0, 0, 0, 0, 0, 0), 10'b11111_0000_1, 1'b0, 0, 0};

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge CLK);

        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            drive(tab[i].s);
            #1;
            cyc++;
            check($sformatf("vec%0d_outputs", i), {22'h0, dut_vec()}, {22'h0, tab[i].o});
            check($sformatf("vec%0d_halted", i), {31'h0, halted}, {31'h0, tab[i].h});
            check($sformatf("vec%0d_stall", i), stall_cnt, perf(tab[i].sc));
            check($sformatf("vec%0d_flush", i), flush_cnt, perf(tab[i].fc));
        end

        // Branch with simultaneous load-use from a clean reset: flush wins.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 0, 1, 0, 1));
        check("brlw_pc_en", {31'h0, pc_en}, 32'h1);
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        check("brlw_flush_cnt", flush_cnt, perf(32'h1));
        check("brlw_stall_cnt", stall_cnt, 32'h0);

        // Halt then hold HALTED for 10+ cycles under random inputs.
        step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        check("drain_memwb_only", {22'h0, dut_vec()}, {22'h0, 10'b00001_0000_0});
        for (int i = 0; i < 12; i++) begin
            stim_t s;
            s = stim_t'($urandom);
            s.rst = 1'b0;
            step(s);
            check("halt_hold", {31'h0, halted}, 32'h1);
        end

        // Reset during DRAIN must beat DRAIN->HALTED.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0));
        step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        check("rst_in_drain_flush", {31'h0, memwb_flush}, 32'h1);
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        check("rst_drain_halted", {31'h0, halted}, 32'h0);
        check("rst_drain_pc_en", {31'h0, pc_en}, 32'h1);
        step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        check("rst_drain_halted2", {31'h0, halted}, 32'h0);

        // Randomized stimulus against the reference model.
        for (int i = 0; i < 1500; i++) begin
            stim_t s;
            s.rst  = ($urandom_range(63) == 0);
            s.ihit = ($urandom_range(3) != 0);
            s.dhit = ($urandom_range(2) == 0);
            s.dren = ($urandom_range(4) == 0);
            s.dwen = ($urandom_range(7) == 0);
            s.halt = ($urandom_range(24) == 0);
            s.lw   = ($urandom_range(5) == 0);
            s.jmp  = ($urandom_range(9) == 0);
            s.brch = ($urandom_range(9) == 0);
            step(s);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline control sequencer that consumes the hazard unit's requests (`lw_nop`, `jmp_flush`, `brch_flush`) and the memory handshakes (`ihit`, `dhit`). It drives the per-stage enable and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It owns the data-memory wait state and the halt drain sequence, and sits between the hazard unit, the memory interface and the datapath latches.

## Interface
- No parameters.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- exmem_dREN, exmem_dWEN  in  1 each  MEM-stage load/store request.
- exmem_halt  in  1  halt instruction present in the MEM stage.
- lw_nop  in  1  load-use hazard in ID.
- jmp_flush, brch_flush  in  1 each  control transfer resolved in EX.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch advance enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble on the next edge.
- imemREN  out  1  instruction read request.
- halted  out  1  registered; sticky halt indication.
- stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration).

## Operation
- States: RUN, DWAIT, DRAIN, HALTED (2-bit encoding); registered.
- Definitions:
  - dreq = exmem_dREN | exmem_dWEN.
  - adv = ihit & (!dreq | dhit).
- RUN:
  - adv=0: all enables 0, all flushes 0 (full freeze).
  - If dreq & !dhit, next state is DWAIT.
- DWAIT:
  - imemREN=0, so the single memory port goes to data.
  - All enables 0, all flushes 0.
  - On dhit: next state is RUN, and this cycle behaves as adv=1 with ihit ignored.
- RUN with adv=1: all enables 1 by default.
  - jmp_flush | brch_flush: ifid_flush=1, idex_flush=1, pc_en=1.
  - lw_nop only: pc_en=0, ifid_en=0, idex_flush=1.
  - Flush and lw_nop together: flush wins (the ID instruction is on the wrong path); lw_nop is ignored.
- exmem_halt & adv in RUN: next state is DRAIN.
  - This cycle: pc_en=0, ifid_flush=1, idex_flush=1, exmem_flush=1.
  - memwb_en=1, so the halt and any prior instruction retire.
- DRAIN:
  - One cycle.
  - memwb_en=1 so the halt instruction completes writeback.
  - All other enables 0, imemREN=0.
  - Next state is HALTED.
- HALTED:
  - All enables 0, all flushes 0, imemREN=0, halted=1.
  - Left only by RST.
- imemREN=1 in RUN, 0 in every other state.
- A flush bit is asserted only together with the matching enable=1, or with enable ignored by the latch.
  - Latches treat flush as priority over enable.

## Timing
- Outputs other than halted and the counters are combinational from state and the current inputs (Mealy), valid in the same cycle.
- State, halted and counters are registered.
- Reset values:
  - State=RUN, halted=0, stall_cnt=0, flush_cnt=0.
  - During the reset cycle, combinational outputs are forced to: enables 0, flushes 1, imemREN 0.
- Load-use stall costs exactly 1 cycle, since the hazard unit drops lw_nop once the bubble is in EX.
- Branch/jump penalty is exactly 2 bubbles (IF/ID and ID/EX).
- DWAIT latency is unbounded and exits the cycle dhit is seen.
- Halt takes 2 cycles from exmem_halt & adv to halted=1.
- RST asserted in any state returns to RUN on the next edge. It takes priority over every transition, including DRAIN→HALTED.

## Configuration
- Macro `PIPE_PERF_EN`.
- Defined:
  - stall_cnt increments every cycle with state DWAIT, or RUN with adv=0, or lw_nop applied.
  - flush_cnt increments every cycle with jmp_flush|brch_flush applied.
  - Both counters wrap modulo 2^32 and freeze in HALTED.
- Undefined: both outputs tied to 32'h0 and no counter flops are built.

## Test plan
- Reset: RST=1 for 2 cycles → state RUN, halted=0, all flushes 1 during reset; first cycle after with ihit=1 → all enables 1, imemREN=1.
- Load-use: lw_nop=1 for one cycle with ihit=1 → pc_en=0, ifid_en=0, idex_flush=1 that cycle; next cycle all enables 1; stall_cnt=1 with PIPE_PERF_EN.
- Branch taken with simultaneous lw_nop=1: brch_flush=1 → ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1, stall_cnt=0.
- Data miss: exmem_dREN=1, dhit=0 for 3 cycles then dhit=1 → DWAIT entered, imemREN=0 and all enables 0 for the wait cycles; enables 1 on the dhit cycle; then RUN.
- Halt: exmem_halt=1 with ihit=1 → exmem_flush=1, memwb_en=1; next cycle DRAIN with only memwb_en=1; halted=1 on the 2nd edge and held for 10 cycles regardless of inputs.
- RST asserted in DRAIN → next edge state RUN, halted=0, counters 0.
